// File: rtl/lfo_sine.sv
// Sine LFO for a modulated delay line. A 24-bit phase accumulator addresses
// a quarter-wave table; the mirrored magnitude is scaled by depth and
// offset around a centre of 256. New rate/depth take effect on a phase wrap
// so the waveform never jumps mid-cycle.
//
// Output timing: sin is registered. sin_strobe is registered alongside it and
// is high for exactly the one cycle in which the freshly registered sin
// differs from the value registered the cycle before. There is no
// backpressure; consumers may sample sin on any cycle.
module lfo_sine (
    input  logic        ADCLRCK,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] rate,
    input  logic [8:0]  depth,
    input  logic        param_load,
    output logic [31:0] sin,
    output logic        sin_strobe,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [23:0] phase_q, phase_d;
    logic [15:0] rate_act_q, rate_act_d, rate_pend_q, rate_pend_d;
    logic [8:0]  depth_act_q, depth_act_d, depth_pend_q, depth_pend_d;
    logic [8:0]  mag_q, mag_d;
    logic        neg_q, neg_d;
    logic [9:0]  sin_q, sin_d;
    logic        strobe_q, strobe_d;

    logic        running;
    logic [24:0] sum;
    logic        wrap;
    logic [8:0]  depth_clamped;
    logic        apply_params;
    logic [6:0]  rom_addr;
    logic [8:0]  scaled;

    // Quarter-wave table: round(256*sin(pi*a/128)); entry 64 is the implicit 256.
    function automatic logic [8:0] quarter_sine(input logic [6:0] a);
        case (a)
            7'd0:  quarter_sine = 9'd0;   7'd1:  quarter_sine = 9'd6;
            7'd2:  quarter_sine = 9'd13;  7'd3:  quarter_sine = 9'd19;
            7'd4:  quarter_sine = 9'd25;  7'd5:  quarter_sine = 9'd31;
            7'd6:  quarter_sine = 9'd38;  7'd7:  quarter_sine = 9'd44;
            7'd8:  quarter_sine = 9'd50;  7'd9:  quarter_sine = 9'd56;
            7'd10: quarter_sine = 9'd62;  7'd11: quarter_sine = 9'd68;
            7'd12: quarter_sine = 9'd74;  7'd13: quarter_sine = 9'd80;
            7'd14: quarter_sine = 9'd86;  7'd15: quarter_sine = 9'd92;
            7'd16: quarter_sine = 9'd98;  7'd17: quarter_sine = 9'd104;
            7'd18: quarter_sine = 9'd109; 7'd19: quarter_sine = 9'd115;
            7'd20: quarter_sine = 9'd121; 7'd21: quarter_sine = 9'd126;
            7'd22: quarter_sine = 9'd132; 7'd23: quarter_sine = 9'd137;
            7'd24: quarter_sine = 9'd142; 7'd25: quarter_sine = 9'd147;
            7'd26: quarter_sine = 9'd152; 7'd27: quarter_sine = 9'd157;
            7'd28: quarter_sine = 9'd162; 7'd29: quarter_sine = 9'd167;
            7'd30: quarter_sine = 9'd172; 7'd31: quarter_sine = 9'd177;
            7'd32: quarter_sine = 9'd181; 7'd33: quarter_sine = 9'd185;
            7'd34: quarter_sine = 9'd190; 7'd35: quarter_sine = 9'd194;
            7'd36: quarter_sine = 9'd198; 7'd37: quarter_sine = 9'd202;
            7'd38: quarter_sine = 9'd206; 7'd39: quarter_sine = 9'd209;
            7'd40: quarter_sine = 9'd213; 7'd41: quarter_sine = 9'd216;
            7'd42: quarter_sine = 9'd220; 7'd43: quarter_sine = 9'd223;
            7'd44: quarter_sine = 9'd226; 7'd45: quarter_sine = 9'd229;
            7'd46: quarter_sine = 9'd231; 7'd47: quarter_sine = 9'd234;
            7'd48: quarter_sine = 9'd237; 7'd49: quarter_sine = 9'd239;
            7'd50: quarter_sine = 9'd241; 7'd51: quarter_sine = 9'd243;
            7'd52: quarter_sine = 9'd245; 7'd53: quarter_sine = 9'd247;
            7'd54: quarter_sine = 9'd248; 7'd55: quarter_sine = 9'd250;
            7'd56: quarter_sine = 9'd251; 7'd57: quarter_sine = 9'd252;
            7'd58: quarter_sine = 9'd253; 7'd59: quarter_sine = 9'd254;
            7'd60: quarter_sine = 9'd255; 7'd61: quarter_sine = 9'd255;
            7'd62: quarter_sine = 9'd256; 7'd63: quarter_sine = 9'd256;
            default: quarter_sine = 9'd256;
        endcase
    endfunction

    // Accumulator add, wrap detection and parameter staging.
    always_comb begin
        running       = (state_q == S_RUN) || (state_q == S_STOP);
        sum           = {1'b0, phase_q} + {9'd0, rate_act_q};
        wrap          = running && sum[24];
        depth_clamped = (depth > 9'd256) ? 9'd256 : depth;
        rate_pend_d   = param_load ? rate : rate_pend_q;
        depth_pend_d  = param_load ? depth_clamped : depth_pend_q;
        // A load in the same cycle as a wrap is forwarded straight to active.
        apply_params  = (state_q == S_IDLE) || wrap;
        rate_act_d    = apply_params ? rate_pend_d : rate_act_q;
        depth_act_d   = apply_params ? depth_pend_d : depth_act_q;
    end

    // Run/stop control: stopping finishes the current cycle and parks at phase 0.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                phase_d = sum[23:0];
                if (!enable) state_d = S_STOP;
            end
            S_STOP: begin
                if (wrap) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = sum[23:0];
                    if (enable) state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Stage 1 mirrors the quadrant into a table lookup; stage 2 scales and signs.
    always_comb begin
        rom_addr = phase_q[22] ? (7'd64 - {1'b0, phase_q[21:16]}) : {1'b0, phase_q[21:16]};
        mag_d    = quarter_sine(rom_addr);
        neg_d    = phase_q[23];
        scaled   = 9'(({9'd0, mag_q} * {9'd0, depth_act_q}) >> 8);
        sin_d    = neg_q ? (10'd256 - {1'b0, scaled}) : (10'd256 + {1'b0, scaled});
        strobe_d = (sin_d != sin_q);
    end

    // State, parameter and pipeline registers.
    always_ff @(posedge ADCLRCK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            rate_act_q   <= '0;
            rate_pend_q  <= '0;
            depth_act_q  <= 9'd256;
            depth_pend_q <= 9'd256;
            mag_q        <= '0;
            neg_q        <= 1'b0;
            sin_q        <= 10'd256;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            rate_act_q   <= rate_act_d;
            rate_pend_q  <= rate_pend_d;
            depth_act_q  <= depth_act_d;
            depth_pend_q <= depth_pend_d;
            mag_q        <= mag_d;
            neg_q        <= neg_d;
            sin_q        <= sin_d;
            strobe_q     <= strobe_d;
        end
    end

    assign sin         = {22'd0, sin_q};
    assign sin_strobe  = strobe_q;
    assign busy        = running;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lfo_sine.sv
// Bench for lfo_sine: directed scenarios followed by random parameter and
// enable traffic, each cycle compared with a behavioural model of the LFO.
module tb_lfo_sine;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] rate_r;
    logic [8:0]  depth_r;
    logic        pl;
    logic [31:0] sin_w;
    logic        strobe_w;
    logic        busy_w;
    logic [1:0]  dbg_w;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: 0 idle, 1 running, 2 stopping.
    int m_state, m_phase, m_prev_phase;
    int m_rate_a, m_depth_a, m_rate_p, m_depth_p;
    int m_sin, m_strobe, m_busy;
    int tbl[65];

    lfo_sine dut (
        .ADCLRCK    (clk),
        .reset      (rst),
        .enable     (en),
        .rate       (rate_r),
        .depth      (depth_r),
        .param_load (pl),
        .sin        (sin_w),
        .sin_strobe (strobe_w),
        .busy       (busy_w),
        .dbg_state_o(dbg_w)
    );

    always #5 clk = ~clk;

    function automatic int model_sin(input int ph, input int d);
        int q, i, mag, sc;
        q   = (ph >> 22) & 3;
        i   = (ph >> 16) & 63;
        mag = (q == 0 || q == 2) ? tbl[i] : tbl[64 - i];
        sc  = (mag * d) >> 8;
        return (q < 2) ? 256 + sc : 256 - sc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int sum, nph, nrp, ndp, new_sin;
        bit wrap;
        if (rst) begin
            m_state = 0; m_phase = 0; m_prev_phase = 0;
            m_rate_a = 0; m_rate_p = 0; m_depth_a = 256; m_depth_p = 256;
            m_sin = 256; m_strobe = 0;
        end else begin
            new_sin  = model_sin(m_prev_phase, m_depth_a);
            m_strobe = (new_sin != m_sin) ? 1 : 0;
            m_sin    = new_sin;
            sum  = m_phase + m_rate_a;
            wrap = (m_state != 0) && (sum >= (1 << 24));
            nrp  = pl ? int'(rate_r) : m_rate_p;
            ndp  = pl ? ((int'(depth_r) > 256) ? 256 : int'(depth_r)) : m_depth_p;
            m_rate_p  = nrp;
            m_depth_p = ndp;
            if (m_state == 0 || wrap) begin
                m_rate_a  = nrp;
                m_depth_a = ndp;
            end
            nph = sum % (1 << 24);
            case (m_state)
                0: begin nph = 0; if (en) m_state = 1; end
                1: if (!en) m_state = 2;
                default: begin
                    if (wrap) begin m_state = 0; nph = 0; end
                    else if (en) m_state = 1;
                end
            endcase
            m_prev_phase = m_phase;
            m_phase      = nph;
        end
        m_busy = (m_state != 0) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("sin", sin_w, m_sin);
        chk("sin_strobe", {31'd0, strobe_w}, m_strobe);
        chk("busy", {31'd0, busy_w}, m_busy);
    endtask

    task automatic load(input logic [15:0] r, input logic [8:0] d);
        pl = 1'b1; rate_r = r; depth_r = d;
        tick();
        pl = 1'b0;
    endtask

    task automatic run_until_phase(input int target, input int budget, input string tag);
        int n = 0;
        while (m_phase != target && n < budget) begin tick(); n++; end
        vectors++;
        assert (m_phase == target) else begin
            miscompares++;
            $error("FAIL %s: phase target not reached, observed cycles %0d expected below %0d", tag, n, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (m_state != 0 && n < budget) begin tick(); n++; end
        vectors++;
        assert (m_state == 0) else begin
            miscompares++;
            $error("FAIL %s: idle not reached, observed cycles %0d expected below %0d", tag, n, budget);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i <= 64; i++)
            tbl[i] = $rtoi(256.0 * $sin(3.141592653589793 * i / 128.0) + 0.5);

        // Reset
        rst = 1'b1; en = 1'b0; pl = 1'b0; rate_r = '0; depth_r = '0;
        tick(); tick();
        chk("reset_sin", sin_w, 256);
        chk("reset_busy", {31'd0, busy_w}, 0);
        rst = 1'b0;
        tick();

        // Full-depth slow sweep: peak at 0x400000, trough at 0xC00000
        load(16'h0400, 9'd256);
        en = 1'b1;
        tick();
        run_until_phase(24'h400000, 20000, "to_peak");
        tick(); tick();
        chk("peak_512", sin_w, 512);
        run_until_phase(24'hC00000, 20000, "to_trough");
        tick(); tick();
        chk("trough_0", sin_w, 0);

        // Mid-cycle load: deferred until the wrap
        load(16'h4000, 9'd128);
        run_until_phase(24'hE00000, 8000, "to_e0");
        tick(); tick();
        chk("deferred_depth", sin_w, 75);
        run_until_phase(24'h400000, 8000, "to_peak_half");
        tick(); tick();
        chk("peak_384", sin_w, 384);
        run_until_phase(24'hC00000, 4000, "to_trough_half");
        tick(); tick();
        chk("trough_128", sin_w, 128);

        // Stop request at 0x500000: busy until wrap, then centre
        run_until_phase(24'h500000, 4000, "to_500000");
        en = 1'b0;
        n = 0;
        while (m_state != 0 && n < 4000) begin
            tick(); n++;
            if (m_state != 0) chk("stopping_busy", {31'd0, busy_w}, 1);
        end
        wait_idle(10, "stop_to_idle");
        chk("idle_busy", {31'd0, busy_w}, 0);
        tick(); tick();
        chk("idle_sin_256", sin_w, 256);

        // Load on the exact wrap cycle: new rate used right away
        en = 1'b1;
        tick();
        n = 0;
        while (!(m_phase + m_rate_a >= (1 << 24)) && n < 4000) begin tick(); n++; end
        pl = 1'b1; rate_r = 16'h8000; depth_r = 9'd256;
        tick();
        pl = 1'b0;
        repeat (130) tick();
        chk("bypass_peak", sin_w, 512);

        // Reset at the peak while running, with competing inputs
        rst = 1'b1; pl = 1'b1; rate_r = 16'h1234; depth_r = 9'd10;
        tick();
        rst = 1'b0; pl = 1'b0; en = 1'b0;
        chk("rst_sin", sin_w, 256);
        chk("rst_busy", {31'd0, busy_w}, 0);
        chk("rst_strobe", {31'd0, strobe_w}, 0);
        load(16'h1000, 9'd256);
        en = 1'b1;
        tick(); tick();
        chk("restart_256", sin_w, 256);
        repeat (300) tick();

        // Rate 0 freezes the phase; pending load never applies
        en = 1'b0;
        wait_idle(6000, "idle_before_rate0");
        load(16'h0000, 9'd256);
        en = 1'b1;
        repeat (40) tick();
        chk("rate0_sin", sin_w, 256);
        load(16'h2000, 9'd256);
        repeat (40) tick();
        chk("rate0_held", sin_w, 256);
        chk("rate0_busy", {31'd0, busy_w}, 1);
        rst = 1'b1; tick(); rst = 1'b0; en = 1'b0;

        // Zero depth: flat centre, no strobes
        load(16'h3000, 9'd0);
        en = 1'b1;
        repeat (600) begin
            tick();
            chk("depth0_sin", sin_w, 256);
            chk("depth0_strobe", {31'd0, strobe_w}, 0);
        end
        en = 1'b0;
        wait_idle(2000, "idle_after_depth0");

        // Over-range depth clamps to 256
        load(16'h5000, 9'd400);
        en = 1'b1;
        repeat (300) tick();

        // Random traffic
        repeat (5000) begin
            tick();
            rst = ($urandom_range(499, 0) == 0);
            pl  = ($urandom_range(15, 0) == 0);
            if (pl) begin
                rate_r  = ($urandom_range(7, 0) == 0) ? 16'h0000 : 16'($urandom_range(65535, 256));
                depth_r = 9'($urandom_range(511, 0));
            end
            if ($urandom_range(63, 0) == 0) en = ~en;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
